pipe_hazard_ctrl: RTL and testbench

- Central stall/flush controller for the 5-stage MIPS pipeline.
- Drives the hold and clear inputs of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Sequences four conditions: load-use hazards, taken branches, the multi-cycle divider and data-memory wait states.
- Also handles exception flushes and keeps a saturating stall-cycle performance counter.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 18 +
 rtl/pipe_hazard_ctrl_sat_counter.sv | 25 ++
 rtl/pipe_hazard_ctrl.sv | 127 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared FSM encodings and widths for the pipeline hazard controller.
// Rev 1.0
`default_nettype none

package pipe_hazard_ctrl_pkg;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_DIV_BUSY = 1'b1
  } hz_state_t;

  localparam int REG_ADDR_WIDTH     = 5;
  localparam int DIV_CYCLES_DEFAULT = 32;
  localparam int DIV_CNT_WIDTH      = 6;

endpackage

`default_nettype wire

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// sat_counter: enabled up-counter with synchronous clear that sticks at all-ones.
// Rev 1.0
`default_nettype none

module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencing for exceptions, memory waits, divides, load-use and branches.
// Rev 1.0
`default_nettype none

module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES     = DIV_CYCLES_DEFAULT,
  parameter int HAS_DELAY_SLOT = 1,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs,
  input  logic [REG_ADDR_WIDTH-1:0] id_rt,
  input  logic                      id_uses_rs,
  input  logic                      id_uses_rt,
  input  logic                      id_branch_taken,
  input  logic                      ex_mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] ex_wa,
  input  logic                      ex_div_start,
  input  logic                      mem_req,
  input  logic                      mem_ready,
  input  logic                      exc_valid,
  output logic                      stall_pc,
  output logic                      stall_if_id,
  output logic                      stall_id_ex,
  output logic                      stall_ex_mem,
  output logic                      flush_if_id,
  output logic                      flush_id_ex,
  output logic                      flush_ex_mem,
  output logic                      flush_mem_wb,
  output logic                      div_done,
  output logic [CNT_WIDTH-1:0]      stall_cnt
);

  // Busy cycles count down to zero after the entry cycle, so the load value
  // makes the entry cycle plus the busy stalls total DIV_CYCLES held cycles.
  localparam logic [DIV_CNT_WIDTH-1:0] C_DIV_LOAD = DIV_CNT_WIDTH'(DIV_CYCLES - 1);

  hz_state_t                r_fsm, w_fsm_nxt;
  logic [DIV_CNT_WIDTH-1:0] r_div_cnt, w_div_cnt_nxt;
  logic                     w_mem_wait;
  logic                     w_load_use;

  assign w_mem_wait = mem_req & ~mem_ready;
  assign w_load_use = ex_mem_read & (ex_wa != '0) &
                      ((id_uses_rs & (id_rs == ex_wa)) | (id_uses_rt & (id_rt == ex_wa)));

  always_comb begin
    stall_pc      = 1'b0;
    stall_if_id   = 1'b0;
    stall_id_ex   = 1'b0;
    stall_ex_mem  = 1'b0;
    flush_if_id   = 1'b0;
    flush_id_ex   = 1'b0;
    flush_ex_mem  = 1'b0;
    flush_mem_wb  = 1'b0;
    div_done      = 1'b0;
    w_fsm_nxt     = r_fsm;
    w_div_cnt_nxt = r_div_cnt;
    if (rst) begin
      w_fsm_nxt     = ST_IDLE;
      w_div_cnt_nxt = '0;
    end else if (exc_valid) begin
      flush_if_id   = 1'b1;
      flush_id_ex   = 1'b1;
      flush_ex_mem  = 1'b1;
      flush_mem_wb  = 1'b1;
      w_fsm_nxt     = ST_IDLE;
      w_div_cnt_nxt = '0;
    end else if (w_mem_wait) begin
      stall_pc     = 1'b1;
      stall_if_id  = 1'b1;
      stall_id_ex  = 1'b1;
      stall_ex_mem = 1'b1;
      flush_mem_wb = 1'b1;
    end else if (r_fsm == ST_DIV_BUSY) begin
      if (r_div_cnt == '0) begin
        div_done  = 1'b1;
        w_fsm_nxt = ST_IDLE;
      end else begin
        stall_pc      = 1'b1;
        stall_if_id   = 1'b1;
        stall_id_ex   = 1'b1;
        flush_ex_mem  = 1'b1;
        w_div_cnt_nxt = r_div_cnt - 1'b1;
      end
    end else if (ex_div_start) begin
      stall_pc      = 1'b1;
      stall_if_id   = 1'b1;
      stall_id_ex   = 1'b1;
      flush_ex_mem  = 1'b1;
      w_fsm_nxt     = ST_DIV_BUSY;
      w_div_cnt_nxt = C_DIV_LOAD;
    end else if (w_load_use) begin
      stall_pc    = 1'b1;
      stall_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if (id_branch_taken) begin
      flush_if_id = (HAS_DELAY_SLOT == 0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm     <= ST_IDLE;
      r_div_cnt <= '0;
    end else begin
      r_fsm     <= w_fsm_nxt;
      r_div_cnt <= w_div_cnt_nxt;
    end
  end

  sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (1'b0),
    .en   (stall_pc),
    .count(stall_cnt)
  );

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of two controller instances (delay slot on / off, 32 / 4-bit counters).
// Rev 1.0
`default_nettype none

module tb_pipe_hazard_ctrl;

  localparam logic [8:0] C_NONE = 9'b0_0000_0000;
  localparam logic [8:0] C_LU   = 9'b1_1000_1000;
  localparam logic [8:0] C_DIV  = 9'b1_1100_0100;
  localparam logic [8:0] C_MW   = 9'b1_1110_0010;
  localparam logic [8:0] C_EXC  = 9'b0_0001_1110;
  localparam logic [8:0] C_DONE = 9'b0_0000_0001;
  localparam logic [8:0] C_BR   = 9'b0_0001_0000;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_wa;
  logic       id_uses_rs, id_uses_rt, id_branch_taken;
  logic       ex_mem_read, ex_div_start, mem_req, mem_ready, exc_valid;

  logic        sp_a, sif_a, sid_a, sem_a, fif_a, fid_a, fem_a, fmw_a, dd_a;
  logic        sp_b, sif_b, sid_b, sem_b, fif_b, fid_b, fem_b, fmw_b, dd_b;
  logic [31:0] cnt_a;
  logic [3:0]  cnt_b;
  logic [8:0]  ctl_a, ctl_b;

  int n_tests = 0;
  int n_fail  = 0;

  assign ctl_a = {sp_a, sif_a, sid_a, sem_a, fif_a, fid_a, fem_a, fmw_a, dd_a};
  assign ctl_b = {sp_b, sif_b, sid_b, sem_b, fif_b, fid_b, fem_b, fmw_b, dd_b};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.DIV_CYCLES(4), .HAS_DELAY_SLOT(1), .CNT_WIDTH(32)) dut_a (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_branch_taken(id_branch_taken),
    .ex_mem_read(ex_mem_read), .ex_wa(ex_wa), .ex_div_start(ex_div_start),
    .mem_req(mem_req), .mem_ready(mem_ready), .exc_valid(exc_valid),
    .stall_pc(sp_a), .stall_if_id(sif_a), .stall_id_ex(sid_a), .stall_ex_mem(sem_a),
    .flush_if_id(fif_a), .flush_id_ex(fid_a), .flush_ex_mem(fem_a), .flush_mem_wb(fmw_a),
    .div_done(dd_a), .stall_cnt(cnt_a)
  );

  pipe_hazard_ctrl #(.DIV_CYCLES(4), .HAS_DELAY_SLOT(0), .CNT_WIDTH(4)) dut_b (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_branch_taken(id_branch_taken),
    .ex_mem_read(ex_mem_read), .ex_wa(ex_wa), .ex_div_start(ex_div_start),
    .mem_req(mem_req), .mem_ready(mem_ready), .exc_valid(exc_valid),
    .stall_pc(sp_b), .stall_if_id(sif_b), .stall_id_ex(sid_b), .stall_ex_mem(sem_b),
    .flush_if_id(fif_b), .flush_id_ex(fid_b), .flush_ex_mem(fem_b), .flush_mem_wb(fmw_b),
    .div_done(dd_b), .stall_cnt(cnt_b)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic idle_inputs();
    id_rs = '0; id_rt = '0; ex_wa = '0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_branch_taken = 1'b0;
    ex_mem_read = 1'b0; ex_div_start = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0; exc_valid = 1'b0;
  endtask

  task automatic load_use_inputs();
    ex_mem_read = 1'b1; ex_wa = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    logic [8:0] div_exp [6];
    logic [8:0] mw_exp [8];
    div_exp = '{C_DIV, C_DIV, C_DIV, C_DIV, C_DONE, C_NONE};
    mw_exp  = '{C_DIV, C_MW, C_MW, C_DIV, C_DIV, C_DIV, C_DONE, C_NONE};

    // Reset gates every output even with hazards present on the inputs.
    idle_inputs();
    rst = 1'b1;
    tick();
    ex_div_start = 1'b1; mem_req = 1'b1; exc_valid = 1'b1;
    sample();
    check("rst_gate_a", 32'(ctl_a), 32'(C_NONE));
    check("rst_gate_b", 32'(ctl_b), 32'(C_NONE));
    tick();
    rst = 1'b0;
    idle_inputs();
    sample();
    check("post_rst_ctl", 32'(ctl_a), 32'(C_NONE));
    check("post_rst_cnt_a", cnt_a, 32'd0);
    check("post_rst_cnt_b", 32'(cnt_b), 32'd0);

    // Load-use: one bubble, then no stall for r0 destination or an unread rt.
    tick();
    load_use_inputs();
    sample();
    check("lu_rs", 32'(ctl_a), 32'(C_LU));
    tick();
    idle_inputs();
    sample();
    check("lu_after", 32'(ctl_a), 32'(C_NONE));
    check("lu_cnt", cnt_a, 32'd1);
    tick();
    ex_mem_read = 1'b1; ex_wa = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
    sample();
    check("lu_r0", 32'(ctl_a), 32'(C_NONE));
    tick();
    ex_mem_read = 1'b1; ex_wa = 5'd8; id_rt = 5'd8; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    sample();
    check("lu_rt_unused", 32'(ctl_a), 32'(C_NONE));
    tick();
    id_uses_rt = 1'b1;
    sample();
    check("lu_rt", 32'(ctl_a), 32'(C_LU));

    // Plain divide: held cycles 0-3, done in cycle 4, idle in cycle 5.
    tick();
    idle_inputs();
    ex_div_start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sample();
      check($sformatf("div_c%0d", i), 32'(ctl_a), 32'(div_exp[i]));
      tick();
      ex_div_start = 1'b0;
    end
    sample();
    check("div_cnt", cnt_a, 32'd6);

    // Divide with memory wait in cycles 1-2; start stays high until the done cycle.
    tick();
    ex_div_start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      mem_req   = (i >= 1 && i <= 3);
      mem_ready = (i == 3);
      ex_div_start = (i <= 6);
      sample();
      check($sformatf("mw_div_c%0d", i), 32'(ctl_a), 32'(mw_exp[i]));
      tick();
    end
    idle_inputs();
    sample();
    check("mw_div_cnt", cnt_a, 32'd12);

    // Exception at busy cycle 2 with a concurrent load-use; divide never completes.
    tick();
    ex_div_start = 1'b1;
    sample();
    check("exc_c0", 32'(ctl_a), 32'(C_DIV));
    tick();
    ex_div_start = 1'b0;
    sample();
    check("exc_c1", 32'(ctl_a), 32'(C_DIV));
    tick();
    exc_valid = 1'b1;
    load_use_inputs();
    sample();
    check("exc_c2", 32'(ctl_a), 32'(C_EXC));
    tick();
    idle_inputs();
    for (int i = 3; i < 8; i++) begin
      sample();
      check($sformatf("exc_idle_c%0d", i), 32'(ctl_a), 32'(C_NONE));
      tick();
    end
    sample();
    check("exc_cnt", cnt_a, 32'd14);

    // Branch: delay slot keeps IF/ID, no delay slot flushes it; load-use outranks it.
    id_branch_taken = 1'b1;
    sample();
    check("br_slot", 32'(ctl_a), 32'(C_NONE));
    check("br_noslot", 32'(ctl_b), 32'(C_BR));
    tick();
    load_use_inputs();
    sample();
    check("br_lu_b", 32'(ctl_b), 32'(C_LU));

    // Reset at busy cycle 1.
    tick();
    idle_inputs();
    ex_div_start = 1'b1;
    sample();
    check("rdiv_c0", 32'(ctl_a), 32'(C_DIV));
    tick();
    ex_div_start = 1'b0;
    rst = 1'b1;
    sample();
    check("rdiv_rst", 32'(ctl_a), 32'(C_NONE));
    tick();
    rst = 1'b0;
    sample();
    check("rdiv_idle", 32'(ctl_a), 32'(C_NONE));
    check("rdiv_cnt", cnt_a, 32'd0);

    // Twenty memory-wait cycles saturate the 4-bit counter at 15.
    tick();
    mem_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sample();
      if (i == 0)  check("mw_hold_ctl", 32'(ctl_b), 32'(C_MW));
      if (i == 14) check("sat_14", 32'(cnt_b), 32'd14);
      if (i == 15) check("sat_15", 32'(cnt_b), 32'd15);
      tick();
    end
    idle_inputs();
    sample();
    check("sat_b_final", 32'(cnt_b), 32'd15);
    check("sat_a_final", cnt_a, 32'd20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
